// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory fetch bus: the controller drives the request and address, memory returns
// ready together with the instruction word (ready qualifies rdata in the same cycle).
interface pc_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program-counter and fetch controller: IDLE -> REQ -> HOLD, with exception, timeout,
// interrupt and redirect handling in strict priority order.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] EXC_VEC   = 32'h8000_0008,
  parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
  parameter int          TIMEOUT   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  pc_fetch_ctrl_if.master        imem,
  output logic                   inst_valid,
  output logic [31:0]            inst,
  output logic [31:0]            inst_pc,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  input  logic                   exc,
  input  logic                   irq,
  output logic [31:0]            epc,
  output logic                   epc_we,
  output logic                   bus_err,
  output logic [1:0]             state_dbg
);

  localparam int CW = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   inst_d, inst_pc_d, epc_d;
  logic          valid_d, epc_we_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout;

  assign imem.imem_req  = (state_q == S_REQ);
  assign imem.imem_addr = pc_q;
  assign state_dbg      = state_q;
  assign timeout        = (state_q == S_REQ) && !imem.imem_ready && (cnt_q == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_VEC;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
      epc        <= '0;
      epc_we     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst       <= inst_d;
      inst_pc    <= inst_pc_d;
      inst_valid <= valid_d;
      epc        <= epc_d;
      epc_we     <= epc_we_d;
      cnt_q      <= cnt_d;
    end
  end

  // Every non-sequential event lands in REQ with a cleared counter and any in-flight data dropped.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst;
    inst_pc_d = inst_pc;
    valid_d   = inst_valid;
    epc_d     = epc;
    epc_we_d  = 1'b0;
    cnt_d     = cnt_q;
    bus_err   = 1'b0;

    if (state_q == S_IDLE) begin
      state_d = S_REQ;
      cnt_d   = '0;
    end else if (exc) begin
      pc_d     = EXC_VEC;
      epc_d    = inst_pc;
      epc_we_d = 1'b1;
      valid_d  = 1'b0;
      state_d  = S_REQ;
      cnt_d    = '0;
    end else if (timeout) begin
      bus_err  = 1'b1;
      pc_d     = EXC_VEC;
      epc_d    = pc_q;
      epc_we_d = 1'b1;
      valid_d  = 1'b0;
      state_d  = S_REQ;
      cnt_d    = '0;
    end else if (irq && (state_q == S_HOLD) && !stall) begin
      pc_d     = IRQ_VEC;
      epc_d    = inst_pc + 32'd4;
      epc_we_d = 1'b1;
      valid_d  = 1'b0;
      state_d  = S_REQ;
      cnt_d    = '0;
    end else if (redirect) begin
      valid_d = 1'b0;
      state_d = S_REQ;
      cnt_d   = '0;
      if (redirect_pc[1:0] == 2'b00) begin
        pc_d = redirect_pc;
      end else begin
        pc_d     = EXC_VEC;
        epc_d    = redirect_pc;
        epc_we_d = 1'b1;
      end
    end else if (state_q == S_REQ) begin
      if (imem.imem_ready) begin
        inst_d    = imem.imem_rdata;
        inst_pc_d = pc_q;
        valid_d   = 1'b1;
        state_d   = S_HOLD;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if ((state_q == S_HOLD) && !stall) begin
      pc_d    = pc_q + 32'd4;
      valid_d = 1'b0;
      state_d = S_REQ;
      cnt_d   = '0;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: memory returns addr + 0x1000_0000 as the instruction word.
module tb_pc_fetch_ctrl;
  localparam logic [31:0] EXC_VEC = 32'h8000_0008;
  localparam logic [31:0] IRQ_VEC = 32'h8000_0004;
  localparam logic [31:0] INST_OFS = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_valid;
  logic [31:0] inst, inst_pc, epc;
  logic        stall, redirect, exc, irq;
  logic [31:0] redirect_pc;
  logic        epc_we, bus_err;
  logic [1:0]  state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  pc_fetch_ctrl_if imem ();

  assign imem.imem_rdata = imem.imem_addr + INST_OFS;

  pc_fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (imem.master),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .exc         (exc),
    .irq         (irq),
    .epc         (epc),
    .epc_we      (epc_we),
    .bus_err     (bus_err),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    exc = 1'b0; irq = 1'b0; imem.imem_ready = 1'b0;
    step(); step();
    check("rst_req", imem.imem_req, 0);
    check("rst_addr", imem.imem_addr, 32'h0);
    check("rst_valid", inst_valid, 0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_epc", epc, 32'h0);
    check("rst_epc_we", epc_we, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_state", state_dbg, 2'd0);

    // Sequential fetch: 0,4,8,C with inst_valid every other cycle
    reset = 1'b0; imem.imem_ready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      check("seq_addr", imem.imem_addr, 32'(4 * i));
      check("seq_req", imem.imem_req, 1);
      check("seq_valid_lo", inst_valid, 0);
      step();
      check("seq_valid_hi", inst_valid, 1);
      check("seq_inst_pc", inst_pc, 32'(4 * i));
      check("seq_inst", inst, 32'(4 * i) + INST_OFS);
      step();
    end
    check("seq_next", imem.imem_addr, 32'h10);

    // Stall in HOLD
    step();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", inst_valid, 1);
      check("stall_inst_pc", inst_pc, 32'h10);
      check("stall_inst", inst, 32'h1000_0010);
      check("stall_req", imem.imem_req, 0);
    end
    stall = 1'b0;
    step();
    check("stall_release_addr", imem.imem_addr, 32'h14);
    check("stall_release_req", imem.imem_req, 1);

    // Aligned redirect coincident with imem_ready drops the data
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    check("redir_addr", imem.imem_addr, 32'h100);
    check("redir_valid", inst_valid, 0);
    check("redir_epc_we", epc_we, 0);
    redirect_pc = 32'h102;
    step();
    check("misal_addr", imem.imem_addr, EXC_VEC);
    check("misal_epc", epc, 32'h102);
    check("misal_epc_we", epc_we, 1);
    check("misal_valid", inst_valid, 0);
    redirect = 1'b0;
    step();
    check("misal_epc_we_drop", epc_we, 0);
    check("misal_hold_pc", inst_pc, EXC_VEC);

    // exc beats irq in HOLD with inst_pc 0x40
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    step();
    check("exc_setup_pc", inst_pc, 32'h40);
    irq = 1'b1; exc = 1'b1;
    step();
    check("exc_addr", imem.imem_addr, EXC_VEC);
    check("exc_epc", epc, 32'h40);
    check("exc_epc_we", epc_we, 1);
    check("exc_valid", inst_valid, 0);
    irq = 1'b0; exc = 1'b0;

    // irq waits while stalled, then is taken
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    step();
    irq = 1'b1; stall = 1'b1;
    step();
    check("irq_stall_valid", inst_valid, 1);
    check("irq_stall_epc_we", epc_we, 0);
    check("irq_stall_state", state_dbg, 2'd2);
    stall = 1'b0;
    step();
    check("irq_addr", imem.imem_addr, IRQ_VEC);
    check("irq_epc", epc, 32'h44);
    check("irq_epc_we", epc_we, 1);
    irq = 1'b0;

    // Bus timeout after 16 REQ cycles without ready
    imem.imem_ready = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      #1;
      check("to_bus_err", bus_err, (k == 16) ? 32'd1 : 32'd0);
      check("to_addr", imem.imem_addr, IRQ_VEC);
      step();
    end
    check("to_exc_addr", imem.imem_addr, EXC_VEC);
    check("to_epc", epc, IRQ_VEC);
    check("to_epc_we", epc_we, 1);
    check("to_bus_err_drop", bus_err, 0);

    // PC wrap from 0xFFFFFFFC
    imem.imem_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    check("wrap_setup", imem.imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_inst", inst, 32'h0FFF_FFFC);
    step();
    check("wrap_addr", imem.imem_addr, 32'h0);

    // Asynchronous reset mid-fetch
    step(); step();
    check("mid_addr", imem.imem_addr, 32'h4);
    check("mid_req", imem.imem_req, 1);
    reset = 1'b1;
    #2;
    check("async_req", imem.imem_req, 0);
    check("async_addr", imem.imem_addr, 32'h0);
    check("async_state", state_dbg, 2'd0);
    check("async_epc", epc, 32'h0);

    // exc/redirect ignored in IDLE
    step();
    reset = 1'b0; exc = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    step();
    check("idle_ign_addr", imem.imem_addr, 32'h0);
    check("idle_ign_epc_we", epc_we, 0);
    check("idle_ign_state", state_dbg, 2'd1);
    exc = 1'b0; redirect = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
